// File: rtl/pattern_response_misr.sv
// ============================================================================
// Module      : pattern_response_misr
// Description : Folds a stream of response samples into a MISR signature and
//               compares it with a golden value at the end of each run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_response_misr #(
    parameter int                DATA_W = 7,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED   = 16'hFFFF,
    parameter int                CNT_W  = 16
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [SIG_W-1:0]  expected_sig,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  sample_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  num_lat;
    logic [SIG_W-1:0]  exp_lat;
    logic              load;
    logic              accept;
    logic [SIG_W-1:0]  misr_next;
    logic [CNT_W-1:0]  count_inc;

    assign sample_ready = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        misr_next  = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                   ^ SIG_W'(sample_in);
        count_inc  = sample_count + 1'b1;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // start is deliberately ignored here; only reset aborts a run
                if (sample_valid) begin
                    accept = 1'b1;
                    if (count_inc == num_lat) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            signature    <= SEED;
            sample_count <= '0;
            num_lat      <= '0;
            exp_lat      <= '0;
            pass         <= 1'b0;
        end else if (load) begin
            num_lat      <= num_samples;
            exp_lat      <= expected_sig;
            signature    <= SEED;
            sample_count <= '0;
            // An empty run lands in DONE immediately with the seed as result
            pass         <= (num_samples == '0) && (SEED == expected_sig);
        end else if (accept) begin
            signature    <= misr_next;
            sample_count <= count_inc;
            if (count_inc == num_lat) begin
                pass <= (misr_next == exp_lat);
            end
        end
    end

endmodule

`default_nettype wire
